// File: rtl/demux14_pkg.sv
// Shared constants and state type for the round-robin demux dispatch sequencer.
package demux14_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRIVE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first ready channel at or after ptr.
module rr_pick4
  import demux14_pkg::*;
(
  input  logic [NUM_CH-1:0] rdy,
  input  logic [SEL_W-1:0]  ptr,
  output logic              found,
  output logic [SEL_W-1:0]  idx
);

  logic [SEL_W-1:0] w_cand;

  // Walk from farthest to nearest so the channel closest to ptr wins.
  always_comb begin
    found  = 1'b0;
    idx    = ptr;
    w_cand = ptr;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      w_cand = ptr + SEL_W'(i);
      if (rdy[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/demux14_rr_sched.sv
// Round-robin dispatch sequencer driving the in/s0/s1 lines of a 1:4 demux.
module demux14_rr_sched
  import demux14_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             rdy0,
  input  logic             rdy1,
  input  logic             rdy2,
  input  logic             rdy3,
  output logic             in,
  output logic             s0,
  output logic             s1,
  output logic             ch_valid,
  output logic [CNT_W-1:0] dispatch_cnt
);

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);

  sched_state_t     r_state, w_state_next;
  logic             r_data, w_data_next;
  logic [SEL_W-1:0] r_ptr, w_ptr_next;
  logic [SEL_W-1:0] r_sel, w_sel_next;
  logic [7:0]       r_hold, w_hold_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_in, w_in_next;
  logic             r_ch_valid, w_ch_valid_next;

  logic             w_found;
  logic [SEL_W-1:0] w_idx;

  rr_pick4 u_pick (
    .rdy   ({rdy3, rdy2, rdy1, rdy0}),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  always_comb begin
    w_state_next    = r_state;
    w_data_next     = r_data;
    w_ptr_next      = r_ptr;
    w_sel_next      = r_sel;
    w_hold_next     = r_hold;
    w_cnt_next      = r_cnt;
    w_in_next       = r_in;
    w_ch_valid_next = r_ch_valid;
    unique case (r_state)
      IDLE: begin
        if (din_valid) begin
          w_data_next  = din;
          w_state_next = SCAN;
        end
      end
      SCAN: begin
        if (w_found) begin
          w_sel_next      = w_idx;
          w_hold_next     = HOLD_INIT;
          w_in_next       = r_data;
          w_ch_valid_next = 1'b1;
          w_state_next    = DRIVE;
        end
      end
      DRIVE: begin
        if (r_hold == 8'd0) begin
          w_ptr_next      = r_sel + SEL_W'(1);
          w_cnt_next      = r_cnt + CNT_W'(1);
          w_in_next       = 1'b0;
          w_ch_valid_next = 1'b0;
          w_state_next    = IDLE;
        end else begin
          w_hold_next = r_hold - 8'd1;
        end
      end
      default: begin
        w_in_next       = 1'b0;
        w_ch_valid_next = 1'b0;
        w_state_next    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_data     <= 1'b0;
      r_ptr      <= '0;
      r_sel      <= '0;
      r_hold     <= 8'd0;
      r_cnt      <= '0;
      r_in       <= 1'b0;
      r_ch_valid <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_data     <= w_data_next;
      r_ptr      <= w_ptr_next;
      r_sel      <= w_sel_next;
      r_hold     <= w_hold_next;
      r_cnt      <= w_cnt_next;
      r_in       <= w_in_next;
      r_ch_valid <= w_ch_valid_next;
    end
  end

  // Select lines come straight from r_sel, which only changes when entering DRIVE.
  assign din_ready    = (r_state == IDLE);
  assign in           = r_in;
  assign s0           = r_sel[0];
  assign s1           = r_sel[1];
  assign ch_valid     = r_ch_valid;
  assign dispatch_cnt = r_cnt;

endmodule
